// File: rtl/ascon_pkg.sv
// ascon_pkg: types and helpers shared by the iterative Ascon permutation core.
//   ascon_state_t : 320-bit state as five 64-bit lanes, x0 in the MSBs.
//   ROUNDS_A/B    : round counts of p12 and p8.
//   round_const   : round constant for round index i (0..11).
//   rotr64        : 64-bit rotate right by a constant amount.
package ascon_pkg;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } ascon_state_t;

  localparam int ROUNDS_A = 12;
  localparam int ROUNDS_B = 8;

  // Upper nibble counts down from 15 while the lower nibble counts up from 0.
  function automatic logic [7:0] round_const(input logic [3:0] i);
    logic [3:0] hi;
    hi = 4'd15 - i;
    return {hi, i};
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// ascon_round: one combinational Ascon round (pc, ps, pl).
//   state_i : input state
//   c_i     : round constant, XORed into x2[7:0]
//   state_o : state after the full round
module ascon_round
  import ascon_pkg::*;
(
  input  ascon_state_t state_i,
  input  logic [7:0]   c_i,
  output ascon_state_t state_o
);

  logic [63:0] a0, a1, a2, a3, a4;   // after constant addition
  logic [63:0] b0, b1, b2, b3, b4;   // s-box input mixing
  logic [63:0] t0, t1, t2, t3, t4;   // chi-like terms
  logic [63:0] c0, c1, c2, c3, c4;   // after nonlinear layer
  logic [63:0] d0, d1, d2, d3, d4;   // s-box output mixing

  // pc
  assign a0 = state_i.x0;
  assign a1 = state_i.x1;
  assign a2 = state_i.x2 ^ {56'd0, c_i};
  assign a3 = state_i.x3;
  assign a4 = state_i.x4;

  // ps, bit-sliced over all 64 columns at once
  assign b0 = a0 ^ a4;
  assign b1 = a1;
  assign b2 = a2 ^ a1;
  assign b3 = a3;
  assign b4 = a4 ^ a3;

  assign t0 = ~b0 & b1;
  assign t1 = ~b1 & b2;
  assign t2 = ~b2 & b3;
  assign t3 = ~b3 & b4;
  assign t4 = ~b4 & b0;

  assign c0 = b0 ^ t1;
  assign c1 = b1 ^ t2;
  assign c2 = b2 ^ t3;
  assign c3 = b3 ^ t4;
  assign c4 = b4 ^ t0;

  assign d0 = c0 ^ c4;
  assign d1 = c1 ^ c0;
  assign d2 = ~c2;
  assign d3 = c3 ^ c2;
  assign d4 = c4;

  // pl
  assign state_o.x0 = d0 ^ rotr64(d0, 19) ^ rotr64(d0, 28);
  assign state_o.x1 = d1 ^ rotr64(d1, 61) ^ rotr64(d1, 39);
  assign state_o.x2 = d2 ^ rotr64(d2, 1)  ^ rotr64(d2, 6);
  assign state_o.x3 = d3 ^ rotr64(d3, 10) ^ rotr64(d3, 17);
  assign state_o.x4 = d4 ^ rotr64(d4, 7)  ^ rotr64(d4, 41);

endmodule

// File: rtl/ascon_perm_iter.sv
// ascon_perm_iter: iterative Ascon permutation, one round per clock.
//   clk, rst            : clock (rising edge), async active-high reset
//   in_valid/in_ready   : job handshake; in_nr (0 or >MAX_ROUNDS -> MAX_ROUNDS)
//   in_state            : 320-bit input state, x0 in [319:256]
//   out_valid/out_ready : result handshake; out_state holds while waiting
//   busy                : high while rounds are being applied (RUN)
module ascon_perm_iter
  import ascon_pkg::*;
#(
  parameter int MAX_ROUNDS = ROUNDS_A
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_nr,
  input  logic [319:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [319:0] out_state,
  output logic         busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] MAX_NR     = 4'(MAX_ROUNDS);
  localparam logic [3:0] IDX_END    = 4'(ROUNDS_A);
  localparam logic [3:0] IDX_PENULT = 4'(ROUNDS_A - 2);

  logic [1:0]   fsm_q, fsm_d;
  ascon_state_t state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic         last_q, last_d;   // next RUN edge applies the final round

  logic [3:0]   nr_eff_s;
  logic [3:0]   i0_s;
  logic         accept_s;
  ascon_state_t rnd_in_s, rnd_out_s;
  logic [7:0]   rnd_c_s;

  assign nr_eff_s = ((in_nr == 4'd0) || (in_nr > MAX_NR)) ? MAX_NR : in_nr;
  assign i0_s     = IDX_END - nr_eff_s;

  // in_ready is forced low while rst is asserted so no job slips in during reset.
  assign in_ready = !rst && ((fsm_q == ST_IDLE) || ((fsm_q == ST_DONE) && out_ready));
  assign accept_s = in_valid && in_ready;

  // The single round instance runs either the fresh job or the stored state.
  assign rnd_in_s = accept_s ? ascon_state_t'(in_state) : state_q;
  assign rnd_c_s  = accept_s ? round_const(i0_s) : round_const(idx_q);

  ascon_round u_round (
    .state_i (rnd_in_s),
    .c_i     (rnd_c_s),
    .state_o (rnd_out_s)
  );

  // Next-state logic for the job FSM, state register and round index.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (accept_s) begin
      state_d = rnd_out_s;
      idx_d   = i0_s + 4'd1;
      last_d  = (i0_s == IDX_PENULT);
      if (nr_eff_s == 4'd1) begin
        fsm_d = ST_DONE;
      end else begin
        fsm_d = ST_RUN;
      end
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          fsm_d = ST_IDLE;
        end
        ST_RUN: begin
          state_d = rnd_out_s;
          idx_d   = idx_q + 4'd1;
          last_d  = (idx_q == IDX_PENULT);
          if (last_q) begin
            fsm_d = ST_DONE;
          end else begin
            fsm_d = ST_RUN;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            fsm_d = ST_IDLE;
          end else begin
            fsm_d = ST_DONE;
          end
        end
        default: begin
          fsm_d = ST_IDLE;
        end
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      idx_q   <= 4'd0;
      last_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = (fsm_q == ST_DONE);
  assign busy      = (fsm_q == ST_RUN);
  assign out_state = state_q;

endmodule

// File: tb/tb_ascon_perm_iter.sv
module tb_ascon_perm_iter;
  import ascon_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_nr;
  logic [319:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [319:0] out_state;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [319:0] exp_q[$];

  ascon_perm_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_nr     (in_nr),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: table-driven s-box applied column by column.
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int ROT1 [5] = '{19, 61, 1, 10, 7};
  localparam int ROT2 [5] = '{28, 39, 6, 17, 41};

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] round_ref(input logic [319:0] s, input int i);
    logic [63:0]  x [5];
    logic [63:0]  y [5];
    logic [4:0]   col;
    logic [4:0]   v;
    logic [319:0] r;
    for (int k = 0; k < 5; k++) x[k] = s[319 - 64*k -: 64];
    x[2][7:0] = x[2][7:0] ^ 8'(((15 - i) << 4) | i);
    for (int j = 0; j < 64; j++) begin
      col = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
      v = SBOX[col];
      for (int k = 0; k < 5; k++) y[k][j] = v[4 - k];
    end
    for (int k = 0; k < 5; k++)
      r[319 - 64*k -: 64] = y[k] ^ ror(y[k], ROT1[k]) ^ ror(y[k], ROT2[k]);
    return r;
  endfunction

  function automatic logic [319:0] perm_ref(input logic [319:0] s, input logic [3:0] nr);
    int ne;
    ne = ((nr == 4'd0) || (nr > 4'd12)) ? 12 : int'(nr);
    for (int i = 12 - ne; i < 12; i++) s = round_ref(s, i);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 320'd1, 320'd0);
    end else begin
      chk(tag, out_state, exp_q.pop_front());
    end
  endtask

  // Wait for out_valid, checking busy meanwhile; returns edges since the accept edge.
  task automatic wait_done(input string tag, output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      chk({tag, "_busy_run"}, 320'(busy), 320'd1);
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // One job: accept, scramble inputs, wait, check latency/result, release.
  task automatic do_job(input logic [319:0] st, input logic [3:0] nr, input int lat,
                        input string tag, output logic [319:0] got);
    int cyc;
    in_valid = 1'b1; in_state = st; in_nr = nr; out_ready = 1'b0;
    chk({tag, "_in_ready"}, 320'(in_ready), 320'd1);
    exp_q.push_back(perm_ref(st, nr));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = {10{$urandom}};
    in_nr    = 4'($urandom);
    wait_done(tag, cyc);
    chk({tag, "_latency"}, 320'(cyc), 320'(lat));
    chk({tag, "_busy_done"}, 320'(busy), 320'd0);
    got = out_state;
    pop_chk({tag, "_state"});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 320'(out_valid), 320'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [319:0] got, st_a, st_b, hold;
    logic [63:0]  k4b;
    int cyc;

    rst = 1'b1; in_valid = 1'b0; in_nr = 4'd0; in_state = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 320'(in_ready), 320'd0);
    chk("rst_out_valid", 320'(out_valid), 320'd0);
    chk("rst_busy", 320'(busy), 320'd0);
    chk("rst_out_state", out_state, 320'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 320'(in_ready), 320'd1);

    // p12 on zero state
    do_job(320'd0, 4'd12, 12, "p12_zero", got);

    // p8 on x4 = 1
    do_job(320'd1, 4'(ROUNDS_B), 8, "p8_one", got);

    // single round on zero state, with lanes checked against hand-derived values
    do_job(320'd0, 4'd1, 1, "p1_zero", got);
    k4b = 64'h4b;
    chk("p1_x4", 320'(got[63:0]), 320'd0);
    chk("p1_x0", 320'(got[319:256]), 320'(k4b ^ {k4b[18:0], k4b[63:19]} ^ {k4b[27:0], k4b[63:28]}));

    // saturation of in_nr
    st_a = {10{$urandom}};
    do_job(st_a, 4'd0,  12, "nr0_sat", got);
    do_job(st_a, 4'd15, 12, "nr15_sat", got);
    do_job({10{$urandom}}, 4'd2, 2, "p2_rand", got);

    // back-to-back: next job waits in DONE, then is accepted on the release edge
    st_a = {10{$urandom}};
    st_b = {10{$urandom}};
    in_valid = 1'b1; in_state = st_a; in_nr = 4'd8; out_ready = 1'b0;
    exp_q.push_back(perm_ref(st_a, 4'd8));
    @(posedge clk); #1;
    in_state = st_b; in_nr = 4'd3;
    chk("b2b_ready_run", 320'(in_ready), 320'd0);
    wait_done("b2b_a", cyc);
    chk("b2b_a_latency", 320'(cyc), 320'd8);
    hold = exp_q[0];
    for (int n = 0; n < 5; n++) begin
      chk("b2b_hold_ready", 320'(in_ready), 320'd0);
      chk("b2b_hold_state", out_state, hold);
      chk("b2b_hold_valid", 320'(out_valid), 320'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("b2b_release_ready", 320'(in_ready), 320'd1);
    pop_chk("b2b_a_state");
    exp_q.push_back(perm_ref(st_b, 4'd3));
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0; in_state = {10{$urandom}};
    chk("b2b_no_bubble_busy", 320'(busy), 320'd1);
    chk("b2b_no_bubble_valid", 320'(out_valid), 320'd0);
    wait_done("b2b_b", cyc);
    chk("b2b_b_latency", 320'(cyc), 320'd3);
    pop_chk("b2b_b_state");
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_b_valid_drop", 320'(out_valid), 320'd0);

    // reset in the middle of a p12 job
    in_valid = 1'b1; in_state = {10{$urandom}}; in_nr = 4'd12;
    exp_q.push_back(perm_ref(in_state, 4'd12));
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("mid_busy_before_rst", 320'(busy), 320'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 320'(out_valid), 320'd0);
    chk("mid_rst_busy", 320'(busy), 320'd0);
    chk("mid_rst_ready", 320'(in_ready), 320'd0);
    chk("mid_rst_state", out_state, 320'd0);
    void'(exp_q.pop_back());
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_still_idle", 320'(out_valid), 320'd0);
    do_job({10{$urandom}}, 4'd12, 12, "p12_after_rst", got);

    chk("queue_drained", 320'(exp_q.size()), 320'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
